// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: state, opcode, ALU and select encodings for the multi-cycle controller
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: funct3/funct7/opcode to ALU control decode for EXEC_R and EXEC_I
module mc_alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       f7,
  output logic [2:0] alu
);
  always_comb
    alu = f3 == 3'b000 ? ((op == OP_R && f7) ? ALU_SUB : ALU_ADD) :
          f3 == 3'b010 ? ALU_SLT :
          f3 == 3'b110 ? ALU_OR  :
          f3 == 3'b111 ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: Moore sequencer for a multi-cycle RV32I-subset core.
// Define PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CW   = 3,
  parameter int RESULT_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          OP,
  input  logic [2:0]          F3,
  input  logic                F7,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                Adr_src,
  output logic                Mem_W,
  output logic                IR_W,
  output logic                PC_W,
  output logic                Reg_W,
  output logic [RESULT_W-1:0] ALU_srcA,
  output logic [RESULT_W-1:0] ALU_srcB,
  output logic [RESULT_W-1:0] Result_src,
  output logic [ALU_CW-1:0]   Alu_control,
  output logic [1:0]          imm_src,
  output logic                illegal
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);
  state_t state, nxt, s;
  logic sticky;
  logic [2:0] dec_alu;
  mc_alu_dec u_dec (.op(OP), .f3(F3), .f7(F7), .alu(dec_alu));
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = (OP == OP_LW || OP == OP_SW) ? S_MEMADR :
                        OP == OP_R   ? S_EXEC_R :
                        OP == OP_I   ? S_EXEC_I :
                        OP == OP_JAL ? S_JAL    :
                        OP == OP_BEQ ? S_BEQ    : S_TRAP;
      S_MEMADR:   nxt = OP == OP_SW ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R, S_EXEC_I, S_JAL: nxt = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:   nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state  <= S_FETCH;
      sticky <= 1'b0;
    end else begin
      state  <= nxt;
      sticky <= sticky | (nxt == S_TRAP);
    end
  // while in reset the selects show FETCH values and the enables are held low
  assign s = reset ? state : S_FETCH;
  always_comb begin
    mem_req     = reset && (s == S_FETCH || s == S_MEMREAD || s == S_MEMWRITE);
    Adr_src     = s == S_MEMREAD || s == S_MEMWRITE;
    Mem_W       = reset && s == S_MEMWRITE;
    IR_W        = reset && s == S_FETCH && mem_ready;
    PC_W        = reset && ((s == S_FETCH && mem_ready) || s == S_JAL || (s == S_BEQ && Zero));
    Reg_W       = reset && (s == S_MEMWB || s == S_ALUWB);
    ALU_srcA    = (s == S_DECODE || s == S_JAL) ? SRCA_OLDPC :
                  (s inside {S_MEMADR, S_EXEC_R, S_EXEC_I, S_BEQ}) ? SRCA_RS1 : SRCA_PC;
    ALU_srcB    = (s == S_FETCH || s == S_JAL) ? SRCB_4 :
                  (s inside {S_DECODE, S_MEMADR, S_EXEC_I}) ? SRCB_IMM : SRCB_RS2;
    Result_src  = s == S_FETCH ? RES_ALU : s == S_MEMWB ? RES_MEM : RES_ALUOUT;
    Alu_control = (s == S_EXEC_R || s == S_EXEC_I) ? dec_alu : s == S_BEQ ? ALU_SUB : ALU_ADD;
    imm_src     = OP == OP_SW ? IMM_S : OP == OP_BEQ ? IMM_B : OP == OP_JAL ? IMM_J : IMM_I;
    illegal     = reset && sticky;
  end
`ifdef PERF_CNT_EN
  always_ff @(posedge clk)
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (nxt == S_FETCH && (state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ}))
        instret_cnt <= instret_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: scoreboard bench with directed per-cycle vectors for the controller
module tb_riscv_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b0, F7 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] OP = 7'b0110011;
  logic [2:0] F3 = 3'b000;
  logic mem_req, Adr_src, Mem_W, IR_W, PC_W, Reg_W, illegal;
  logic [1:0] ALU_srcA, ALU_srcB, Result_src, imm_src;
  logic [2:0] Alu_control;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  riscv_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .OP(OP), .F3(F3), .F7(F7), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .Adr_src(Adr_src), .Mem_W(Mem_W), .IR_W(IR_W), .PC_W(PC_W), .Reg_W(Reg_W),
    .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB), .Result_src(Result_src),
    .Alu_control(Alu_control), .imm_src(imm_src), .illegal(illegal)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );
  always #5 clk = ~clk;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
  localparam logic [6:0] JAL = 7'b1101111, BEQ = 7'b1100011, BAD = 7'b1111111;
  // {mem_req, Adr_src, Mem_W, IR_W, PC_W, Reg_W, srcA, srcB, Result_src, Alu_control, imm_src, illegal}
  localparam logic [17:0] E_RST  = 18'b0_0_0_0_0_0_00_10_10_000_00_0;
  localparam logic [17:0] E_FW   = 18'b1_0_0_0_0_0_00_10_10_000_00_0;
  localparam logic [17:0] E_FR   = 18'b1_0_0_1_1_0_00_10_10_000_00_0;
  localparam logic [17:0] E_DEC  = 18'b0_0_0_0_0_0_01_01_00_000_00_0;
  localparam logic [17:0] E_MA   = 18'b0_0_0_0_0_0_10_01_00_000_00_0;
  localparam logic [17:0] E_MR   = 18'b1_1_0_0_0_0_00_00_00_000_00_0;
  localparam logic [17:0] E_MWB  = 18'b0_0_0_0_0_1_00_00_01_000_00_0;
  localparam logic [17:0] E_MW   = 18'b1_1_1_0_0_0_00_00_00_000_00_0;
  localparam logic [17:0] E_EXR  = 18'b0_0_0_0_0_0_10_00_00_000_00_0;
  localparam logic [17:0] E_EXI  = 18'b0_0_0_0_0_0_10_01_00_000_00_0;
  localparam logic [17:0] E_AWB  = 18'b0_0_0_0_0_1_00_00_00_000_00_0;
  localparam logic [17:0] E_JAL  = 18'b0_0_0_0_1_0_01_10_00_000_00_0;
  localparam logic [17:0] E_BEQ0 = 18'b0_0_0_0_0_0_10_00_00_001_00_0;
  localparam logic [17:0] E_BEQ1 = 18'b0_0_0_0_1_0_10_00_00_001_00_0;
  localparam logic [17:0] E_TRAP = 18'b0_0_0_0_0_0_00_00_00_000_00_1;
  // fields a state leaves unspecified are masked out
  localparam logic [17:0] F_A = 18'h10000, F_S = 18'h00F00, F_R = 18'h000C0, M_ALL = 18'h3FFFF;
  localparam logic [17:0] M_SEL = M_ALL & ~(F_A | F_R), M_MEM = M_ALL & ~(F_S | F_R);
  localparam logic [17:0] M_WB = M_ALL & ~(F_A | F_S), M_PC = M_ALL & ~F_A;
  localparam logic [17:0] M_TRAP = M_ALL & ~(F_A | F_S | F_R);
  typedef struct {
    logic [17:0] e;
    logic [17:0] m;
    string       name;
    logic        pc;
    logic [31:0] cyc;
    logic [31:0] ins;
  } item_t;
  item_t q[$];
  int n_vec = 0, n_bad = 0;
  logic [17:0] act;
  assign act = {mem_req, Adr_src, Mem_W, IR_W, PC_W, Reg_W, ALU_srcA, ALU_srcB, Result_src,
                Alu_control, imm_src, illegal};
  function automatic logic [17:0] a(input logic [2:0] x);
    return {12'd0, x, 3'd0};
  endfunction
  function automatic logic [1:0] imm_of(input logic [6:0] op);
    return op == SW ? 2'b01 : op == BEQ ? 2'b10 : op == JAL ? 2'b11 : 2'b00;
  endfunction
  always @(negedge clk)
    while (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      n_vec++;
      if (it.pc) begin
`ifdef PERF_CNT_EN
        if (cycle_cnt !== it.cyc || instret_cnt !== it.ins) begin
          n_bad++;
          $display("FAIL %s: cycle_cnt=%0d instret_cnt=%0d, want %0d/%0d", it.name, cycle_cnt,
                   instret_cnt, it.cyc, it.ins);
        end
`endif
      end else if ((act & it.m) !== (it.e & it.m)) begin
        n_bad++;
        $display("FAIL %s: got %b want %b (mask %b)", it.name, act, it.e, it.m);
      end
    end
  task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy, input logic [17:0] e, input logic [17:0] m,
                      input string nm);
    item_t it;
    reset = r; OP = op; F3 = f3; F7 = f7; Zero = z; mem_ready = rdy;
    it.e = e | {15'd0, imm_of(op), 1'b0};
    it.m = m; it.name = nm; it.pc = 1'b0; it.cyc = '0; it.ins = '0;
    q.push_back(it);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  task automatic perf_exp(input logic [31:0] cyc, input logic [31:0] ins);
    item_t it;
    it.e = '0; it.m = '0; it.name = "perf"; it.pc = 1'b1; it.cyc = cyc; it.ins = ins;
    q.push_back(it);
  endtask
  task automatic alu_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [17:0] ex, input string nm);
    step(1, op, f3, f7, 0, 1, E_FR, M_ALL, {nm, "_fetch"});
    step(1, op, f3, f7, 0, 1, E_DEC, M_SEL, {nm, "_decode"});
    step(1, op, f3, f7, 0, 1, ex, M_SEL, {nm, "_exec"});
    step(1, op, f3, f7, 0, 1, E_AWB, M_WB, {nm, "_aluwb"});
  endtask
  task automatic sw_ins(input int waits);
    step(1, SW, 3'b010, 0, 0, 1, E_FR, M_ALL, "sw_fetch");
    step(1, SW, 3'b010, 0, 0, 1, E_DEC, M_SEL, "sw_decode");
    step(1, SW, 3'b010, 0, 0, 1, E_MA, M_SEL, "sw_memadr");
    for (int i = 0; i < waits; i++) step(1, SW, 3'b010, 0, 0, 0, E_MW, M_MEM, "sw_memwrite_wait");
    step(1, SW, 3'b010, 0, 0, 1, E_MW, M_MEM, "sw_memwrite");
  endtask
  task automatic jal_ins();
    step(1, JAL, 3'b000, 0, 0, 1, E_FR, M_ALL, "jal_fetch");
    step(1, JAL, 3'b000, 0, 0, 1, E_DEC, M_SEL, "jal_decode");
    step(1, JAL, 3'b000, 0, 0, 1, E_JAL, M_PC, "jal_jal");
    step(1, JAL, 3'b000, 0, 0, 1, E_AWB, M_WB, "jal_aluwb");
  endtask
  task automatic beq_ins(input logic z);
    step(1, BEQ, 3'b000, 0, z, 1, E_FR, M_ALL, "beq_fetch");
    step(1, BEQ, 3'b000, 0, z, 1, E_DEC, M_SEL, "beq_decode");
    step(1, BEQ, 3'b000, 0, z, 1, z ? E_BEQ1 : E_BEQ0, M_PC, z ? "beq_taken" : "beq_not_taken");
  endtask
  initial begin
    @(posedge clk);
    #1;
    repeat (3) step(0, R, 3'b000, 1, 0, 1, E_RST, M_ALL, "in_reset");
    alu_ins(R, 3'b000, 1, E_EXR | a(3'b001), "sub");
    step(1, R, 3'b111, 0, 0, 0, E_FW, M_ALL, "fetch_wait");
    alu_ins(R, 3'b111, 0, E_EXR | a(3'b010), "and");
    alu_ins(I, 3'b010, 0, E_EXI | a(3'b101), "slti");
    alu_ins(I, 3'b110, 1, E_EXI | a(3'b011), "ori");
    alu_ins(I, 3'b000, 1, E_EXI | a(3'b000), "addi_f7");
    alu_ins(R, 3'b001, 1, E_EXR | a(3'b000), "r_f3_001");
    step(1, LW, 3'b010, 0, 0, 1, E_FR, M_ALL, "lw_fetch");
    step(1, LW, 3'b010, 0, 0, 1, E_DEC, M_SEL, "lw_decode");
    step(1, LW, 3'b010, 0, 0, 1, E_MA, M_SEL, "lw_memadr");
    repeat (2) step(1, LW, 3'b010, 0, 0, 0, E_MR, M_MEM, "lw_memread_wait");
    step(1, LW, 3'b010, 0, 0, 1, E_MR, M_MEM, "lw_memread");
    step(1, LW, 3'b010, 0, 0, 1, E_MWB, M_WB, "lw_memwb");
    beq_ins(1);
    beq_ins(0);
    sw_ins(1);
    jal_ins();
    step(1, LW, 3'b010, 0, 0, 1, E_FR, M_ALL, "abort_fetch");
    step(1, LW, 3'b010, 0, 0, 1, E_DEC, M_SEL, "abort_decode");
    step(1, LW, 3'b010, 0, 0, 1, E_MA, M_SEL, "abort_memadr");
    step(1, LW, 3'b010, 0, 0, 0, E_MR, M_MEM, "abort_memread");
    step(0, LW, 3'b010, 0, 0, 1, E_RST, M_ALL, "abort_reset");
    alu_ins(R, 3'b000, 1, E_EXR | a(3'b001), "after_abort");
    step(1, BAD, 3'b000, 0, 0, 1, E_FR, M_ALL, "bad_fetch");
    step(1, BAD, 3'b000, 0, 0, 1, E_DEC, M_SEL, "bad_decode");
    repeat (10) step(1, BAD, 3'b000, 0, 1, 1, E_TRAP, M_TRAP, "trap");
    step(0, BAD, 3'b000, 0, 0, 1, E_RST, M_ALL, "trap_reset");
    sw_ins(0);
    jal_ins();
    alu_ins(I, 3'b000, 0, E_EXI | a(3'b000), "addi");
    step(1, R, 3'b000, 0, 0, 1, E_FR, M_ALL, "post_fetch");
`ifdef PERF_CNT_EN
    perf_exp(32'd13, 32'd3);
`endif
    step(1, R, 3'b000, 0, 0, 1, E_DEC, M_SEL, "post_decode");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Moore-style sequencing controller for a multi-cycle RV32I-subset core. The core has one shared instruction/data memory with a ready handshake, plus an instruction register (IR), an ALUOut register, an OldPC register and the existing ALU, register file and immediate extender. Each cycle the block decodes the latched opcode and drives the select lines and write enables. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
ALU_CW, 3, width of the ALU control output.
RESULT_W, 2, width of the result-mux and ALU operand selects.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
OP  in  7  IR[6:0].
F3  in  3  IR[14:12].
F7  in  1  IR[30].
Zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access request.
Adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
Mem_W  out  1  memory write enable.
IR_W  out  1  IR and OldPC load enable.
PC_W  out  1  PC load enable.
Reg_W  out  1  register file write enable.
ALU_srcA  out  2  operand A select: 00 = PC, 01 = OldPC, 10 = rs1.
ALU_srcB  out  2  operand B select: 00 = rs2, 01 = imm, 10 = constant 4.
Result_src  out  2  result mux select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
Alu_control  out  ALU_CW  000 add, 001 sub, 010 and, 011 or, 101 slt.
imm_src  out  2  extender select: 00 I, 01 S, 10 B, 11 J.
illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset: synchronous, active-low. Clock and reset are fixed as stated in Ports.
  - reset=0 at a rising edge sets the state to FETCH and clears illegal.
  - While reset=0, PC_W, IR_W, Reg_W, Mem_W and mem_req are forced to 0.
  - While reset=0, all other outputs take their FETCH decode values.
  - Reset asserted mid-instruction aborts the instruction with no partial writes.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, JAL, BEQ, TRAP. All outputs are decoded from the state; some write enables are also gated by mem_ready.
- FETCH:
  - Drives mem_req=1, Adr_src=0, ALU_srcA=00, ALU_srcB=10, Alu_control=add, Result_src=10.
  - Waits while mem_ready=0 with IR_W=PC_W=0.
  - When mem_ready=1: IR_W=1, PC_W=1, next state DECODE.
- DECODE:
  - Drives ALU_srcA=01, ALU_srcB=01, add (computes the branch/jump target into ALUOut).
  - Next state: lw/sw (0000011/0100011) -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1101111 -> JAL; 1100011 -> BEQ; any other opcode -> TRAP.
- MEMADR: drives ALU_srcA=10, ALU_srcB=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: drives mem_req=1, Adr_src=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: drives Result_src=01, Reg_W=1. Next state FETCH.
- MEMWRITE: drives mem_req=1, Adr_src=1, Mem_W=1; all three held until the cycle mem_ready=1 inclusive. Then FETCH.
- EXEC_R: drives ALU_srcA=10, ALU_srcB=00. Next state ALUWB.
- EXEC_I: drives ALU_srcA=10, ALU_srcB=01. Next state ALUWB.
- ALUWB: drives Result_src=00, Reg_W=1. Next state FETCH.
- JAL: drives ALU_srcA=01, ALU_srcB=10, add, Result_src=00, PC_W=1. Next state ALUWB, which writes PC+4 to rd.
- BEQ: drives ALU_srcA=10, ALU_srcB=00, sub, Result_src=00, PC_W=Zero. Next state FETCH.
- TRAP: illegal=1; every write enable and mem_req is 0. Only reset leaves TRAP.
- ALU decode (in EXEC_R and EXEC_I only; add elsewhere, except sub in BEQ):
  - F3 000: sub when the instruction is R-type and F7=1, otherwise add.
  - F3 010 -> slt; F3 110 -> or; F3 111 -> and.
  - Any other F3 -> add. This is not trapped.
- imm_src comes combinationally from OP: sw -> 01, beq -> 10, jal -> 11, otherwise 00.
- Write-enable exclusivity: Reg_W and Mem_W are never 1 in the same cycle; PC_W and Reg_W coincide only in JAL→ALUWB ordering across cycles, never in one cycle.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both cleared by reset.
  - cycle_cnt increments every cycle while reset=1 and the state is not TRAP.
  - instret_cnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both counters wrap modulo 2^32.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - the state encoding (4-bit localparams);
  - opcode constants;
  - the ALU_CW codes;
  - the ALU_srcA, ALU_srcB and Result_src select encodings;
  - the imm_src codes.
- One sub-module, mc_alu_dec: combinational F3/F7/opcode → Alu_control decoder.
- The FSM and output decode stay in riscv_multicycle_ctrl.

Test Plan:
- Reset held low 3 cycles, then released with mem_ready=1 → during reset all enables 0 and illegal=0; first cycle after release: FETCH with IR_W=PC_W=1.
- R-type sub (OP=0110011, F3=000, F7=1), mem_ready=1 → FETCH, DECODE, EXEC_R (Alu_control=001), ALUWB (Reg_W=1); 4 cycles total.
- lw with mem_ready low 2 extra cycles in MEMREAD → mem_req/Adr_src held for 3 cycles, Reg_W=1 exactly once in MEMWB; 7 cycles total.
- beq with Zero=1, then again with Zero=0 → PC_W=1 in BEQ for the first, 0 for the second; Alu_control=001 in both.
- OP=1111111 → TRAP after DECODE; illegal=1 and all enables 0 for 10 cycles; reset=0 for one edge → FETCH, illegal=0.
- PERF_CNT_EN: run sw, jal, addi with mem_ready=1 → instret_cnt=3, cycle_cnt=13.
